// File: rtl/branch_ctrl.sv
// Branch/jump resolution unit for a multi-cycle core.
// A request is captured in IDLE, compared in CMP, resolved in TGT and
// presented in RESP until the consumer takes it. Statistics counters track
// completed legal conditional branches and how many of them were taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side accepts only in IDLE (req_ready=1). The
// response side holds resp_valid and all result outputs stable in RESP until
// resp_ready is seen high, and ignores resp_ready in every other state.
//
// Timing: the request is captured at edge N, CMP runs until edge N+1, TGT
// until edge N+2, and resp_valid is high from edge N+2 onward, so a consumer
// holding resp_ready=1 samples it at edge N+3. With an always-ready consumer
// the next request can be accepted at edge N+4.
module branch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] link,
  output logic        misalign,
  output logic        illegal,
  input  logic        cnt_clr,
  output logic [31:0] br_count,
  output logic [31:0] taken_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    TGT  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;

  // Captured request
  logic [2:0]  f3_q;
  logic        jal_q;
  logic        jalr_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] pc_q;
  logic [31:0] imm_q;

  // Comparison results from CMP
  logic        eq_q;
  logic        lt_q;
  logic        ltu_q;

  // Resolution results computed from the captured request during TGT
  logic        is_cond;
  logic        bad_f3;
  logic        cond_taken;
  logic        illegal_n;
  logic        taken_n;
  logic [31:0] target_n;
  logic [31:0] link_n;
  logic        misalign_n;

  logic        resp_hs;

  assign dbg_state = state;
  assign resp_hs   = (state == RESP) && resp_ready;

  // Resolve the captured instruction into taken/target/link/flags
  always_comb begin
    is_cond    = !jal_q && !jalr_q;
    bad_f3     = 1'b0;
    cond_taken = 1'b0;
    case (f3_q)
      3'b000:  cond_taken = eq_q;
      3'b001:  cond_taken = !eq_q;
      3'b100:  cond_taken = lt_q;
      3'b101:  cond_taken = !lt_q;
      3'b110:  cond_taken = ltu_q;
      3'b111:  cond_taken = !ltu_q;
      default: bad_f3     = 1'b1;
    endcase
    // Both jump flags at once is treated as illegal, just like a bad funct3
    illegal_n = (jal_q && jalr_q) || (is_cond && bad_f3);
    taken_n   = !illegal_n && (is_cond ? cond_taken : 1'b1);
    link_n    = pc_q + 32'd4;
    if (!taken_n) begin
      target_n = link_n;
    end else if (jalr_q) begin
      target_n = (rs1_q + imm_q) & ~32'd1;
    end else begin
      target_n = pc_q + imm_q;
    end
    misalign_n = taken_n && (target_n[1:0] != 2'b00);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      taken      <= 1'b0;
      target     <= 32'd0;
      link       <= 32'd0;
      misalign   <= 1'b0;
      illegal    <= 1'b0;
      f3_q       <= 3'd0;
      jal_q      <= 1'b0;
      jalr_q     <= 1'b0;
      rs1_q      <= 32'd0;
      rs2_q      <= 32'd0;
      pc_q       <= 32'd0;
      imm_q      <= 32'd0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      ltu_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q      <= funct3;
            jal_q     <= is_jal;
            jalr_q    <= is_jalr;
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            pc_q      <= pc;
            imm_q     <= imm;
            req_ready <= 1'b0;
            state     <= CMP;
          end
        end
        CMP: begin
          eq_q  <= (rs1_q == rs2_q);
          lt_q  <= ($signed(rs1_q) < $signed(rs2_q));
          ltu_q <= (rs1_q < rs2_q);
          state <= TGT;
        end
        TGT: begin
          taken      <= taken_n;
          target     <= target_n;
          link       <= link_n;
          misalign   <= misalign_n;
          illegal    <= illegal_n;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Statistics: count legal conditional branches as their responses complete
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      br_count    <= 32'd0;
      taken_count <= 32'd0;
    end else if (resp_hs && !jal_q && !jalr_q && !illegal) begin
      br_count <= br_count + 32'd1;
      if (taken) begin
        taken_count <= taken_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl. Inputs change and outputs are sampled on
// the falling edge; the DUT works on the rising edge.
module tb_branch_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        resp_valid;
  logic        resp_ready;
  logic        taken;
  logic [31:0] target;
  logic [31:0] link;
  logic        misalign;
  logic        illegal;
  logic        cnt_clr;
  logic [31:0] br_count;
  logic [31:0] taken_count;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  branch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .funct3      (funct3),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .rs1         (rs1),
    .rs2         (rs2),
    .pc          (pc),
    .imm         (imm),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .taken       (taken),
    .target      (target),
    .link        (link),
    .misalign    (misalign),
    .illegal     (illegal),
    .cnt_clr     (cnt_clr),
    .br_count    (br_count),
    .taken_count (taken_count),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input logic [31:0] e_br, input logic [31:0] e_tk);
    chk({tag, "_br_count"}, br_count, e_br);
    chk({tag, "_taken_count"}, taken_count, e_tk);
  endtask

  // Present one request for exactly one accept edge, then scramble the
  // request inputs so that any late sampling shows up in the results.
  task automatic send(input logic [2:0] f3, input logic j, input logic jr,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] i);
    chk("pre_req_ready", {31'd0, req_ready}, 32'd1);
    funct3    = f3;
    is_jal    = j;
    is_jalr   = jr;
    rs1       = a;
    rs2       = b;
    pc        = p;
    imm       = i;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    funct3    = 3'($urandom_range(0, 7));
    is_jal    = 1'($urandom_range(0, 1));
    is_jalr   = 1'($urandom_range(0, 1));
    rs1       = $urandom;
    rs2       = $urandom;
    pc        = $urandom;
    imm       = $urandom;
  endtask

  // Full transaction with an always-ready consumer. clr raises cnt_clr on
  // the handshake edge; wrap preloads br_count with all-ones just before it.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic j, input logic jr,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i,
                        input logic e_taken, input logic [31:0] e_tgt,
                        input logic e_mis, input logic e_ill,
                        input logic clr, input logic wrap);
    resp_ready = 1'b1;
    send(f3, j, jr, a, b, p, i);
    chk({tag, "_cmp_state"}, {30'd0, dbg_state}, 32'd1);
    chk({tag, "_cmp_req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_cmp_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    tick();
    chk({tag, "_tgt_state"}, {30'd0, dbg_state}, 32'd2);
    chk({tag, "_tgt_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    tick();
    chk({tag, "_resp_state"}, {30'd0, dbg_state}, 32'd3);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_taken"}, {31'd0, taken}, {31'd0, e_taken});
    chk({tag, "_target"}, target, e_tgt);
    chk({tag, "_link"}, link, p + 32'd4);
    chk({tag, "_misalign"}, {31'd0, misalign}, {31'd0, e_mis});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, e_ill});
    if (wrap) begin
      force dut.br_count = 32'hFFFF_FFFF;
      #1;
      release dut.br_count;
    end
    cnt_clr = clr;
    tick();
    cnt_clr = 1'b0;
    chk({tag, "_done_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_done_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    cnt_clr    = 1'b0;
    funct3     = 3'd0;
    is_jal     = 1'b0;
    is_jalr    = 1'b0;
    rs1        = 32'd0;
    rs2        = 32'd0;
    pc         = 32'd0;
    imm        = 32'd0;

    // Reset state
    @(negedge clk);
    tick();
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_link", link, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    check_counts("rst", 32'd0, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // BEQ taken; resp_ready is already high before RESP
    run_op("beq", 3'b000, 1'b0, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20,
           1'b1, 32'h120, 1'b0, 1'b0, 1'b0, 1'b0);
    check_counts("beq", 32'd1, 32'd1);

    // Clear while idle: counters drop, FSM unaffected
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_counts("clr_idle", 32'd0, 32'd0);
    chk("clr_idle_state", {30'd0, dbg_state}, 32'd0);

    // Signed vs unsigned less-than on the same operands
    run_op("blt", 3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40,
           1'b1, 32'h240, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("bltu", 3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40,
           1'b0, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
    check_counts("blt_bltu", 32'd2, 32'd1);

    // BNE taken with a negative offset
    run_op("bne", 3'b001, 1'b0, 1'b0, 32'd5, 32'd6, 32'h300, 32'hFFFF_FFF0,
           1'b1, 32'h2F0, 1'b0, 1'b0, 1'b0, 1'b0);
    // BGE: 1 >= -1 signed
    run_op("bge", 3'b101, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h400, 32'h8,
           1'b1, 32'h408, 1'b0, 1'b0, 1'b0, 1'b0);
    // BGEU: 1 < 0xFFFFFFFF unsigned, not taken
    run_op("bgeu", 3'b111, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h400, 32'h8,
           1'b0, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
    // Taken branch to a misaligned target still counts
    run_op("beq_mis", 3'b000, 1'b0, 1'b0, 32'd7, 32'd7, 32'h500, 32'h2,
           1'b1, 32'h502, 1'b1, 1'b0, 1'b0, 1'b0);
    check_counts("cond_mix", 32'd6, 32'd4);

    // JALR clears bit 0 and lands on a half-word boundary
    run_op("jalr", 3'b000, 1'b0, 1'b1, 32'h1003, 32'd0, 32'h600, 32'h4,
           1'b1, 32'h1006, 1'b1, 1'b0, 1'b0, 1'b0);
    // JAL with pc+imm and pc+4 both wrapping past 2^32
    run_op("jal_wrap", 3'b000, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8,
           1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    // Both jump flags: illegal
    run_op("jj_ill", 3'b000, 1'b1, 1'b1, 32'd0, 32'd0, 32'h700, 32'h40,
           1'b0, 32'h704, 1'b0, 1'b1, 1'b0, 1'b0);
    check_counts("jumps", 32'd6, 32'd4);

    // Illegal funct3 under backpressure
    resp_ready = 1'b0;
    send(3'b010, 1'b0, 1'b0, 32'd3, 32'd3, 32'h800, 32'h10);
    tick();
    tick();
    chk("bp_resp_valid_first", {31'd0, resp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      tick();
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_illegal", {31'd0, illegal}, 32'd1);
      chk("bp_taken", {31'd0, taken}, 32'd0);
      chk("bp_target", target, 32'h804);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("bp_done_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_done_req_ready", {31'd0, req_ready}, 32'd1);
    check_counts("bp", 32'd6, 32'd4);

    // Reset while in CMP: request is dropped
    send(3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'h900, 32'h10);
    chk("midrst_in_cmp", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_taken", {31'd0, taken}, 32'd0);
    chk("midrst_target", target, 32'd0);
    chk("midrst_link", link, 32'd0);
    chk("midrst_misalign", {31'd0, misalign}, 32'd0);
    chk("midrst_illegal", {31'd0, illegal}, 32'd0);
    check_counts("midrst", 32'd0, 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_rel_req_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    // cnt_clr wins over a counted handshake on the same edge
    run_op("clr_hs", 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'hA00, 32'h8,
           1'b1, 32'hA08, 1'b0, 1'b0, 1'b1, 1'b0);
    check_counts("clr_hs", 32'd0, 32'd0);

    run_op("beq2", 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'hB00, 32'h8,
           1'b1, 32'hB08, 1'b0, 1'b0, 1'b0, 1'b0);
    check_counts("beq2", 32'd1, 32'd1);

    // br_count wraps from all-ones to zero on a counted not-taken branch
    run_op("wrap", 3'b001, 1'b0, 1'b0, 32'd4, 32'd4, 32'hC00, 32'h8,
           1'b0, 32'hC04, 1'b0, 1'b0, 1'b0, 1'b1);
    check_counts("wrap", 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
